// File: rtl/counter_seq_checker_if.sv
// counter_seq_checker_if
// Bundles the signals a sequence checker observes on a counter (enable, count,
// start/stop control) together with the checker's status outputs.
// The master side drives the observed counter signals and control; the slave
// side is the checker itself.
interface counter_seq_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             en;
  logic [WIDTH-1:0] count;
  logic             start;
  logic             stop;
  logic             locked;
  logic             mismatch;
  logic [ERR_W-1:0] err_cnt;
  logic [WIDTH-1:0] expected;

  modport master (
    output en, count, start, stop,
    input  locked, mismatch, err_cnt, expected
  );

  modport slave (
    input  en, count, start, stop,
    output locked, mismatch, err_cnt, expected
  );
endinterface

// File: rtl/counter_seq_checker.sv
// counter_seq_checker
// Receive-side checker for a free-running enable counter. It watches the enable
// fed to the counter and the count it returns, predicts the next count, and
// reports each deviation as a single-cycle mismatch pulse. After a deviation
// the prediction is resynchronised to the observed value, so a counter that
// jumps once produces one pulse rather than a continuous stream.
//
// Optional feature macro: COUNT_SEQ_CHECKER_ERRCNT_EN
//   defined   -> err_cnt is a saturating count of mismatches (cleared by rst only)
//   undefined -> no error counter register, err_cnt is tied to zero
module counter_seq_checker #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  counter_seq_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    TRACK
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] expected_q;
  logic             locked_q;
  logic             mismatch_q;
  logic [WIDTH-1:0] next_pred;

`ifdef COUNT_SEQ_CHECKER_ERRCNT_EN
  logic [ERR_W-1:0] err_q;
`endif

  // Prediction of the count one cycle ahead; the carry out of the top bit is
  // dropped so an all-ones count with enable predicts zero.
  always_comb begin
    next_pred = bus.count + WIDTH'(bus.en);
  end

  // Checker sequencing: IDLE waits for start, SYNC loads the first prediction
  // from the observed count, TRACK compares and resynchronises every cycle.
  // stop has priority over everything except rst and leaves expected/err held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      expected_q <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
`ifdef COUNT_SEQ_CHECKER_ERRCNT_EN
      err_q      <= '0;
`endif
    end else begin
      mismatch_q <= 1'b0;
      if (bus.stop) begin
        state    <= IDLE;
        locked_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            locked_q <= 1'b0;
            if (bus.start) begin
              state <= SYNC;
            end
          end
          SYNC: begin
            locked_q   <= 1'b0;
            expected_q <= next_pred;
            state      <= TRACK;
          end
          TRACK: begin
            expected_q <= next_pred;
            if (bus.count == expected_q) begin
              locked_q <= 1'b1;
            end else begin
              locked_q   <= 1'b0;
              mismatch_q <= 1'b1;
`ifdef COUNT_SEQ_CHECKER_ERRCNT_EN
              if (err_q != {ERR_W{1'b1}}) begin
                err_q <= err_q + ERR_W'(1);
              end
`endif
            end
          end
          default: begin
            state    <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked   = locked_q;
  assign bus.mismatch = mismatch_q;
  assign bus.expected = expected_q;

`ifdef COUNT_SEQ_CHECKER_ERRCNT_EN
  assign bus.err_cnt  = err_q;
`else
  assign bus.err_cnt  = {ERR_W{1'b0}};
`endif

endmodule

// File: doc/counter_seq_checker.md
# counter_seq_checker

Synthesizable receive-side checker for the counter interface: observes the enable driven into the counter and the count it returns, predicts every count value, and flags deviations. Sits on the same clock and reset as the counter and is the hardware counterpart of the bench checker. Used in self-checking builds and on silicon debug, where no bench is present.

## Interface
Parameters:
- WIDTH, 4, width of the observed count; must match the counter.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset, shared with the counter.
- en  in  1  enable as sampled by the counter.
- count  in  WIDTH  counter output.
- start  in  1  begin checking (level or pulse, sampled in IDLE).
- stop  in  1  stop checking, return to IDLE.
- locked  out  1  prediction currently agrees with count.
- mismatch  out  1  one-cycle pulse per detected deviation.
- err_cnt  out  ERR_W  saturating number of mismatches.
- expected  out  WIDTH  current predicted count (debug).

## Operation
- Counter model: count(n+1) = (count(n) + en(n)) mod 2^WIDTH; count = 0 in any cycle following rst high.
- States: IDLE, SYNC, TRACK.
- IDLE: no comparisons; locked = 0. start=1 -> SYNC.
- SYNC (one cycle): expected <= count + en (mod 2^WIDTH); -> TRACK. No compare this cycle.
- TRACK, each cycle: compare count to expected.
  - Equal: expected <= count + en; locked <= 1.
  - Different: mismatch <= 1 for next cycle only; locked <= 0; err_cnt increments (saturates at 2^ERR_W-1, never wraps); expected <= count + en (resync to observed value, so one disturbance yields one mismatch, not a stream).
- stop=1 in any state -> IDLE next cycle; err_cnt held, expected held, locked <= 0. stop and start in the same cycle: stop wins.
- start while in SYNC/TRACK ignored.
- Arithmetic: expected is WIDTH bits, increment drops carry; 2^WIDTH-1 with en=1 predicts 0.
- err_cnt cleared only by rst.

## Timing
- Reset (rst high at an edge): state IDLE, locked=0, mismatch=0, err_cnt=0, expected=0. Reset mid-TRACK aborts immediately; no mismatch is reported for the reset cycle.
- start high at edge k (IDLE) -> SYNC at k+1 -> first compare at k+2.
- Compare in cycle n -> mismatch/locked/err_cnt updated at edge n+1 (latency 1, all outputs registered).
- First successful compare: locked high one cycle after that compare.
- Back-to-back deviations in consecutive cycles: one mismatch pulse each, err_cnt +1 each.
- en and count sampled in the same cycle; no combinational path input-to-output.

## Configuration
- Macro COUNT_SEQ_CHECKER_ERRCNT_EN.
- Defined: err_cnt is the saturating counter described above.
- Undefined: no error counter register; err_cnt tied to 0; mismatch and locked unchanged.

## Test plan
- Reset then start, en=1 every cycle for 20 cycles on a good WIDTH=4 counter -> locked=1 from third cycle after start, count wraps 15->0 with no mismatch, err_cnt=0.
- Random en pattern (e.g. 1,0,0,1,1,0,1) for 50 cycles on good counter -> mismatch never asserted, expected tracks count every cycle.
- Force count to 9 when 5 expected during TRACK, one cycle -> exactly one mismatch pulse one cycle later, err_cnt=1, locked low one cycle, relocks after next match.
- Stuck count (en=1, count frozen) for 300 cycles with ERR_W=8 -> mismatch each cycle, err_cnt saturates at 255 and stays.
- start and stop asserted together in IDLE -> stays IDLE; stop during TRACK -> IDLE next cycle, err_cnt held.
- rst high mid-TRACK with err_cnt=3 -> all outputs 0 next cycle, state IDLE; build without COUNT_SEQ_CHECKER_ERRCNT_EN -> err_cnt constantly 0 in scenario 3.
